kv_cmd_issuer: RTL and testbench
================================

Name: kv_cmd_issuer

Overview:
- Initiator side of the key-value store request interface (store signal codes: 0 = search, 1 = insert, 2 = transact).
- Buffers host commands in a small FIFO and issues them to the store one at a time.
- Holds each request stable for a fixed store latency, samples updated_value/value_addr, and returns a response over a valid/ready handshake.
- Replaces hand-timed stimulus with a hardware sequencer.

Parameters:
- KEY_WIDTH, 32, key width.
- VALUE_WIDTH, 32, value, transact amount and result width.
- ADDR_WIDTH, 32, value_addr width.
- FIFO_DEPTH_BITS, 3, command FIFO depth = 2**FIFO_DEPTH_BITS (8).
- STORE_LATENCY, 4, cycles a request is held before the result is sampled; legal range 1..255.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  0 search, 1 insert, 2 transact, 3 illegal.
- cmd_key  in  KEY_WIDTH  key.
- cmd_value  in  VALUE_WIDTH  insert value or transact amount.
- cmd_kind  in  1  transact kind (0 debit, 1 credit).
- ram_enable  out  1  store enable.
- write_enable  out  1  store write strobe.
- key  out  KEY_WIDTH  to store.
- signal  out  2  to store; 3 = idle.
- value  out  VALUE_WIDTH  insert value to store.
- transact_value  out  VALUE_WIDTH  transact amount to store.
- transact_kind  out  1  to store.
- updated_value  in  VALUE_WIDTH  store result.
- value_addr  in  ADDR_WIDTH  store value address.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_op  out  2  echoed op.
- rsp_key  out  KEY_WIDTH  echoed key.
- rsp_data  out  VALUE_WIDTH  sampled updated_value.
- rsp_addr  out  ADDR_WIDTH  sampled value_addr.
- rsp_err  out  1  illegal op.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset values:
  - All outputs 0, except signal = 3 and cmd_ready = 1.
  - FIFO is emptied, state = IDLE, latency counter = 0.
- Command FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full.
  - A push and a pop in the same cycle are both allowed. When full, the simultaneous pop frees the slot the following cycle; cmd_ready is not combinationally looped.
  - Pointers are FIFO_DEPTH_BITS+1 wide and wrap naturally.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - FIFO non-empty: pop the head into a request register.
    - Op 3: go to RESP with rsp_err = 1, rsp_data = 0, rsp_addr = 0. No store access.
    - Otherwise: go to ISSUE.
  - ISSUE (1 cycle):
    - Drive ram_enable = 1, key, signal = op.
    - Insert: value = cmd_value. Transact: transact_value = cmd_value, transact_kind = cmd_kind.
    - write_enable = 1 for insert and transact, 0 for search.
    - Load counter = STORE_LATENCY-1, then go to WAIT.
  - WAIT:
    - Hold all store outputs stable; write_enable drops to 0 after ISSUE.
    - Decrement the counter each cycle.
    - When the counter is 0: register updated_value → rsp_data and value_addr → rsp_addr, drive signal = 3, ram_enable = 0, go to RESP.
  - RESP:
    - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready.
    - On rsp_ready: rsp_valid = 0 next cycle, return to IDLE.
- Latency and throughput:
  - Push to first store cycle: 2 cycles when the FIFO is empty and the FSM is idle.
  - Store outputs are held for 1 + STORE_LATENCY cycles.
  - Minimum period per command: STORE_LATENCY + 3 cycles with rsp_ready tied high.
- Ordering: strictly in order; one outstanding store request at a time.
- Reset mid-operation: any state returns to IDLE next cycle. The in-flight request and FIFO contents are discarded and no response is emitted.

Optional Feature:
- Macro: KV_ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_issued (16 bits, counts ISSUE entries) and stat_illegal (16 bits, counts op-3 commands).
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: these ports and their logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then insert key=279, value=7623, rsp_ready=1 → signal=1 and write_enable=1 for exactly one cycle, value=7623 held 5 cycles, rsp_valid with rsp_key=279, rsp_data = store updated_value.
- Back-to-back push of insert key=524/value=3423 and search key=279 → two responses in order, second has rsp_op=0 with write_enable never asserted; no overlap in signal activity.
- Transact key=249, kind=1, value=100 → transact_value=100, transact_kind=1, signal=2 for 5 cycles, rsp_data sampled on the last WAIT cycle.
- Push 9 commands with rsp_ready=0 → cmd_ready=0 once the FIFO is full; releasing rsp_ready drains all commands in order with no loss.
- cmd_op=3, key=7 → rsp_err=1, rsp_data=0, ram_enable stays 0; with KV_ISSUE_STATS_EN, stat_illegal=1 and stat_issued unchanged.
- Assert reset during WAIT → next cycle signal=3, ram_enable=0, rsp_valid=0, cmd_ready=1, busy=0.

Source files
------------

// File: rtl/kv_cmd_issuer.sv
// Key-value store request sequencer: FIFOs host commands, issues them one at a time, returns responses.
// Optional KV_ISSUE_STATS_EN adds saturating stat_issued / stat_illegal counters.
module kv_cmd_issuer #(
  parameter int unsigned KEY_WIDTH       = 32,
  parameter int unsigned VALUE_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_BITS = 3,
  parameter int unsigned STORE_LATENCY   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  input  logic                   cmd_kind,
  output logic                   ram_enable,
  output logic                   write_enable,
  output logic [KEY_WIDTH-1:0]   key,
  output logic [1:0]             signal,
  output logic [VALUE_WIDTH-1:0] value,
  output logic [VALUE_WIDTH-1:0] transact_value,
  output logic                   transact_kind,
  input  logic [VALUE_WIDTH-1:0] updated_value,
  input  logic [ADDR_WIDTH-1:0]  value_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_op,
  output logic [KEY_WIDTH-1:0]   rsp_key,
  output logic [VALUE_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  output logic                   rsp_err,
  output logic                   busy
`ifdef KV_ISSUE_STATS_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_illegal
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned PTR_W = FIFO_DEPTH_BITS + 1;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [1:0]             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    logic                   kind;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  cmd_t                   fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       fifo_count, count_next;
  logic                   push, pop;
  cmd_t                   head;
  logic [1:0]             req_op_q, req_op_d;
  logic [KEY_WIDTH-1:0]   req_key_q, req_key_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   cmd_ready_q, cmd_ready_d;
  logic                   ram_enable_q, ram_enable_d;
  logic                   write_enable_q, write_enable_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [1:0]             signal_q, signal_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [VALUE_WIDTH-1:0] transact_value_q, transact_value_d;
  logic                   transact_kind_q, transact_kind_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_op_q, rsp_op_d;
  logic [KEY_WIDTH-1:0]   rsp_key_q, rsp_key_d;
  logic [VALUE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0]  rsp_addr_q, rsp_addr_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy_q, busy_d;
  logic [15:0]            stat_issued_q, stat_issued_d;
  logic [15:0]            stat_illegal_q, stat_illegal_d;

  // FIFO bookkeeping; ready/busy are registered from next-cycle occupancy
  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    push       = cmd_valid && cmd_ready_q;
    pop        = (state_q == S_IDLE) && (fifo_count != '0);
    head       = fifo_mem_q[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_next = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= '{op: cmd_op, key: cmd_key,
                                                              value: cmd_value, kind: cmd_kind};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = (head.op == 2'd3) ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless a transition updates it
  always_comb begin
    req_op_d         = req_op_q;
    req_key_d        = req_key_q;
    cnt_d            = cnt_q;
    ram_enable_d     = ram_enable_q;
    write_enable_d   = write_enable_q;
    key_d            = key_q;
    signal_d         = signal_q;
    value_d          = value_q;
    transact_value_d = transact_value_q;
    transact_kind_d  = transact_kind_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_op_d         = rsp_op_q;
    rsp_key_d        = rsp_key_q;
    rsp_data_d       = rsp_data_q;
    rsp_addr_d       = rsp_addr_q;
    rsp_err_d        = rsp_err_q;
    stat_issued_d    = stat_issued_q;
    stat_illegal_d   = stat_illegal_q;
    cmd_ready_d      = (count_next != PTR_W'(DEPTH));
    busy_d           = (state_d != S_IDLE) || (count_next != '0);
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          req_op_d  = head.op;
          req_key_d = head.key;
          if (head.op == 2'd3) begin
            rsp_valid_d = 1'b1;
            rsp_op_d    = head.op;
            rsp_key_d   = head.key;
            rsp_data_d  = '0;
            rsp_addr_d  = '0;
            rsp_err_d   = 1'b1;
            if (stat_illegal_q != 16'hFFFF) stat_illegal_d = stat_illegal_q + 16'd1;
          end else begin
            ram_enable_d   = 1'b1;
            write_enable_d = (head.op != 2'd0);
            key_d          = head.key;
            signal_d       = head.op;
            if (head.op == 2'd1) value_d = head.value;
            if (head.op == 2'd2) begin
              transact_value_d = head.value;
              transact_kind_d  = head.kind;
            end
            if (stat_issued_q != 16'hFFFF) stat_issued_d = stat_issued_q + 16'd1;
          end
        end
      end
      S_ISSUE: begin
        write_enable_d = 1'b0;
        cnt_d          = CNT_W'(STORE_LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          signal_d     = 2'd3;
          ram_enable_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_op_d     = req_op_q;
          rsp_key_d    = req_key_q;
          rsp_data_d   = updated_value;
          rsp_addr_d   = value_addr;
          rsp_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      req_op_q         <= '0;
      req_key_q        <= '0;
      cnt_q            <= '0;
      cmd_ready_q      <= 1'b1;
      ram_enable_q     <= 1'b0;
      write_enable_q   <= 1'b0;
      key_q            <= '0;
      signal_q         <= 2'd3;
      value_q          <= '0;
      transact_value_q <= '0;
      transact_kind_q  <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_op_q         <= '0;
      rsp_key_q        <= '0;
      rsp_data_q       <= '0;
      rsp_addr_q       <= '0;
      rsp_err_q        <= 1'b0;
      busy_q           <= 1'b0;
      stat_issued_q    <= '0;
      stat_illegal_q   <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      req_op_q         <= req_op_d;
      req_key_q        <= req_key_d;
      cnt_q            <= cnt_d;
      cmd_ready_q      <= cmd_ready_d;
      ram_enable_q     <= ram_enable_d;
      write_enable_q   <= write_enable_d;
      key_q            <= key_d;
      signal_q         <= signal_d;
      value_q          <= value_d;
      transact_value_q <= transact_value_d;
      transact_kind_q  <= transact_kind_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_op_q         <= rsp_op_d;
      rsp_key_q        <= rsp_key_d;
      rsp_data_q       <= rsp_data_d;
      rsp_addr_q       <= rsp_addr_d;
      rsp_err_q        <= rsp_err_d;
      busy_q           <= busy_d;
      stat_issued_q    <= stat_issued_d;
      stat_illegal_q   <= stat_illegal_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign ram_enable     = ram_enable_q;
  assign write_enable   = write_enable_q;
  assign key            = key_q;
  assign signal         = signal_q;
  assign value          = value_q;
  assign transact_value = transact_value_q;
  assign transact_kind  = transact_kind_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_op         = rsp_op_q;
  assign rsp_key        = rsp_key_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = busy_q;
`ifdef KV_ISSUE_STATS_EN
  assign stat_issued    = stat_issued_q;
  assign stat_illegal   = stat_illegal_q;
`else
  logic unused_stats;
  assign unused_stats = ^{stat_issued_q, stat_illegal_q};
`endif

endmodule

// File: tb/tb_kv_cmd_issuer.sv
// Directed self-checking bench for kv_cmd_issuer with a cycle-indexed store model.
module tb_kv_cmd_issuer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_key, cmd_value;
  logic        cmd_kind;
  logic        ram_enable, write_enable;
  logic [31:0] key;
  logic [1:0]  signal;
  logic [31:0] value, transact_value;
  logic        transact_kind;
  logic [31:0] updated_value, value_addr;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_key, rsp_data, rsp_addr;
  logic        rsp_err, busy;
`ifdef KV_ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_illegal;
`endif

  int unsigned tb_cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) tb_cyc <= tb_cyc + 1;

  // Store model: result and address are a function of the cycle they are sampled in
  assign updated_value = tb_cyc + 32'h1000;
  assign value_addr    = 32'hA000_0000 | tb_cyc;

  kv_cmd_issuer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .cmd_value(cmd_value), .cmd_kind(cmd_kind),
    .ram_enable(ram_enable), .write_enable(write_enable), .key(key), .signal(signal),
    .value(value), .transact_value(transact_value), .transact_kind(transact_kind),
    .updated_value(updated_value), .value_addr(value_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_key(rsp_key),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy)
`ifdef KV_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_illegal(stat_illegal)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_key = 0; cmd_value = 0; cmd_kind = 0; rsp_ready = 0;
    do_reset();
    n_cmp++; if (signal !== 2'd3) begin n_bad++; $display("FAIL rst_signal got %0d want 3", signal); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if (ram_enable !== 1'b0) begin n_bad++; $display("FAIL rst_ram_enable got %b want 0", ram_enable); end
    n_cmp++; if (write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_write_enable got %b want 0", write_enable); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (key !== 32'd0 || value !== 32'd0 || rsp_data !== 32'd0) begin
      n_bad++; $display("FAIL rst_data got key=%0d value=%0d rsp_data=%0d want 0", key, value, rsp_data); end
  endtask

  task automatic test_insert();
    int unsigned p0;
    logic [31:0] exp_d;
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'd1; cmd_key = 279; cmd_value = 7623; cmd_kind = 0;
    p0 = tb_cyc;
    tick();
    cmd_valid = 0;
    n_cmp++; if (ram_enable !== 1'b0) begin n_bad++; $display("FAIL ins_early_ram got %b want 0", ram_enable); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ins_busy got %b want 1", busy); end
    tick();
    for (int o = 2; o <= 6; o++) begin
      n_cmp++; if (signal !== 2'd1 || ram_enable !== 1'b1 || key !== 32'd279) begin
        n_bad++; $display("FAIL ins_store_c%0d got sig=%0d en=%b key=%0d want 1/1/279", o, signal, ram_enable, key); end
      n_cmp++; if (value !== 32'd7623) begin n_bad++; $display("FAIL ins_value_c%0d got %0d want 7623", o, value); end
      n_cmp++; if (write_enable !== (o == 2)) begin
        n_bad++; $display("FAIL ins_we_c%0d got %b want %b", o, write_enable, (o == 2)); end
      tick();
    end
    exp_d = p0 + 6 + 32'h1000;
    n_cmp++; if (signal !== 2'd3 || ram_enable !== 1'b0) begin
      n_bad++; $display("FAIL ins_release got sig=%0d en=%b want 3/0", signal, ram_enable); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_key !== 32'd279 || rsp_op !== 2'd1 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL ins_rsp got v=%b key=%0d op=%0d err=%b want 1/279/1/0", rsp_valid, rsp_key, rsp_op, rsp_err); end
    n_cmp++; if (rsp_data !== exp_d || rsp_addr !== (32'hA000_0000 | (p0 + 6))) begin
      n_bad++; $display("FAIL ins_rsp_data got %h/%h want %h/%h", rsp_data, rsp_addr, exp_d, 32'hA000_0000 | (p0 + 6)); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ins_done got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int unsigned p0;
    logic [1:0] e_sig;
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'd1; cmd_key = 524; cmd_value = 3423; cmd_kind = 0;
    p0 = tb_cyc;
    tick();
    for (int o = 1; o <= 15; o++) begin
      if (o == 1) begin cmd_op = 2'd0; cmd_key = 279; cmd_value = 0; end
      if (o == 2) cmd_valid = 0;
      e_sig = (o >= 2 && o <= 6) ? 2'd1 : (o >= 9 && o <= 13) ? 2'd0 : 2'd3;
      n_cmp++; if (signal !== e_sig) begin n_bad++; $display("FAIL b2b_sig_c%0d got %0d want %0d", o, signal, e_sig); end
      n_cmp++; if (write_enable !== (o == 2)) begin
        n_bad++; $display("FAIL b2b_we_c%0d got %b want %b", o, write_enable, (o == 2)); end
      n_cmp++; if (rsp_valid !== (o == 7 || o == 14)) begin
        n_bad++; $display("FAIL b2b_rv_c%0d got %b want %b", o, rsp_valid, (o == 7 || o == 14)); end
      if (o == 7) begin
        n_cmp++; if (rsp_key !== 32'd524 || rsp_op !== 2'd1 || rsp_data !== p0 + 6 + 32'h1000) begin
          n_bad++; $display("FAIL b2b_rsp0 got key=%0d op=%0d d=%h want 524/1/%h", rsp_key, rsp_op, rsp_data, p0 + 6 + 32'h1000); end
      end
      if (o == 14) begin
        n_cmp++; if (rsp_key !== 32'd279 || rsp_op !== 2'd0 || rsp_data !== p0 + 13 + 32'h1000) begin
          n_bad++; $display("FAIL b2b_rsp1 got key=%0d op=%0d d=%h want 279/0/%h", rsp_key, rsp_op, rsp_data, p0 + 13 + 32'h1000); end
      end
      tick();
    end
  endtask

  task automatic test_transact();
    int unsigned p0;
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'd2; cmd_key = 249; cmd_value = 100; cmd_kind = 1;
    p0 = tb_cyc;
    tick();
    cmd_valid = 0;
    tick();
    for (int o = 2; o <= 6; o++) begin
      n_cmp++; if (signal !== 2'd2 || transact_value !== 32'd100 || transact_kind !== 1'b1 || key !== 32'd249) begin
        n_bad++; $display("FAIL tr_store_c%0d got sig=%0d tv=%0d tk=%b key=%0d want 2/100/1/249",
                          o, signal, transact_value, transact_kind, key); end
      n_cmp++; if (write_enable !== (o == 2)) begin
        n_bad++; $display("FAIL tr_we_c%0d got %b want %b", o, write_enable, (o == 2)); end
      tick();
    end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== 2'd2 || rsp_data !== p0 + 6 + 32'h1000 || signal !== 2'd3) begin
      n_bad++; $display("FAIL tr_rsp got v=%b op=%0d d=%h sig=%0d want 1/2/%h/3", rsp_valid, rsp_op, rsp_data, signal, p0 + 6 + 32'h1000); end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] got_key [$];
    logic [1:0]  got_op [$];
    int          guard;
    rsp_ready = 0;
    cmd_valid = 1;
    for (int i = 0; i < 9; i++) begin
      cmd_op = 2'(i % 3); cmd_key = 32'(100 + i); cmd_value = 32'(i * 10); cmd_kind = 1'(i & 1);
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ff_ready_c%0d got %b want 1", i, cmd_ready); end
      tick();
    end
    cmd_valid = 0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ff_full got %b want 0", cmd_ready); end
    tick(); tick(); tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_key !== 32'd100 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL ff_stall got v=%b key=%0d rdy=%b busy=%b want 1/100/0/1", rsp_valid, rsp_key, cmd_ready, busy); end
    rsp_ready = 1;
    guard = 0;
    while (got_key.size() < 9 && guard < 300) begin
      if (rsp_valid) begin got_key.push_back(rsp_key); got_op.push_back(rsp_op); end
      tick();
      guard++;
    end
    n_cmp++; if (got_key.size() != 9) begin n_bad++; $display("FAIL ff_count got %0d want 9", got_key.size()); end
    for (int i = 0; i < got_key.size(); i++) begin
      n_cmp++; if (got_key[i] !== 32'(100 + i) || got_op[i] !== 2'(i % 3)) begin
        n_bad++; $display("FAIL ff_order_%0d got key=%0d op=%0d want %0d/%0d", i, got_key[i], got_op[i], 100 + i, i % 3); end
    end
    guard = 0;
    while (busy && guard < 20) begin tick(); guard++; end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL ff_drained got busy=%b rdy=%b want 0/1", busy, cmd_ready); end
  endtask

  task automatic test_illegal();
    do_reset();
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'd3; cmd_key = 7; cmd_value = 55; cmd_kind = 0;
    tick();
    cmd_valid = 0;
    n_cmp++; if (ram_enable !== 1'b0) begin n_bad++; $display("FAIL ill_ram_c1 got %b want 0", ram_enable); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_op !== 2'd3 || rsp_key !== 32'd7) begin
      n_bad++; $display("FAIL ill_rsp got v=%b err=%b op=%0d key=%0d want 1/1/3/7", rsp_valid, rsp_err, rsp_op, rsp_key); end
    n_cmp++; if (rsp_data !== 32'd0 || rsp_addr !== 32'd0 || ram_enable !== 1'b0 || signal !== 2'd3) begin
      n_bad++; $display("FAIL ill_data got d=%h a=%h en=%b sig=%0d want 0/0/0/3", rsp_data, rsp_addr, ram_enable, signal); end
`ifdef KV_ISSUE_STATS_EN
    n_cmp++; if (stat_illegal !== 16'd1 || stat_issued !== 16'd0) begin
      n_bad++; $display("FAIL ill_stats got ill=%0d iss=%0d want 1/0", stat_illegal, stat_issued); end
`endif
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ram_enable !== 1'b0) begin
      n_bad++; $display("FAIL ill_done got v=%b busy=%b en=%b want 0/0/0", rsp_valid, busy, ram_enable); end
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1;
    cmd_valid = 1; cmd_op = 2'd1; cmd_key = 11; cmd_value = 5; cmd_kind = 0;
    tick();
    cmd_key = 12;
    tick();
    cmd_valid = 0;
    tick(); tick();
    n_cmp++; if (signal !== 2'd1 || ram_enable !== 1'b1) begin
      n_bad++; $display("FAIL rm_in_wait got sig=%0d en=%b want 1/1", signal, ram_enable); end
    reset = 1;
    tick();
    reset = 0;
    n_cmp++; if (signal !== 2'd3 || ram_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rm_after got sig=%0d en=%b v=%b rdy=%b busy=%b want 3/0/0/1/0",
                        signal, ram_enable, rsp_valid, cmd_ready, busy); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid || ram_enable || busy) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rm_discard got %0d active cycles want 0", seen); end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_insert();
    test_back_to_back();
    test_transact();
    test_fifo_full();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
